piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 130 +++++++++++++
 tb/tb_piso_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a Width-bit word, shifts it out LSB first.
// Optional even-parity trailer bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
   parameter int Width = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [Width-1:0] Data,
   input  logic             Load_valid,
   output logic             Load_ready,
   output logic             Sout,
   output logic             Sout_valid,
   output logic             Busy,
   output logic             Done
);

   localparam int CntW = $clog2(Width + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
`ifdef PISO_TX_PARITY_EN
      PARITY = 2'd2,
`endif
      SHIFT  = 2'd1
   } state_e;

   state_e            state_q, state_d;
   logic [Width-1:0]  sreg_q, sreg_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              done_q, done_d;
`ifdef PISO_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   // State, shift register, bit counter and completion flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef PISO_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next-state logic; Done is raised on the transition into IDLE that ends a frame.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (Load_valid) begin
               state_d = SHIFT;
               sreg_d  = Data;
               cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
               par_d   = ^Data;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sreg_d = {1'b0, sreg_q[Width-1:1]};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == LastCnt) begin
`ifdef PISO_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               state_d = SHIFT;
            end
         end
`ifdef PISO_TX_PARITY_EN
         PARITY: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from registered state only; no path from Load_valid.
   always_comb begin
      Load_ready = (state_q == IDLE);
      Busy       = (state_q != IDLE);
      Done       = done_q;
      Sout       = 1'b0;
      Sout_valid = 1'b0;
      case (state_q)
         SHIFT: begin
            Sout       = sreg_q[0];
            Sout_valid = 1'b1;
         end
`ifdef PISO_TX_PARITY_EN
         PARITY: begin
            Sout       = par_q;
            Sout_valid = 1'b1;
         end
`endif
         default: begin
            Sout       = 1'b0;
            Sout_valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_tx.sv
// Table-driven bench for piso_tx (Width=4 and Width=8 instances), with
// hand-written sequences for mid-frame reset and the Width=8 counter limit.
module tb_piso_tx;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [3:0] data4 = 4'd0;
   logic       lv4 = 1'b0;
   logic       rdy4, sout4, sv4, busy4, done4;
   logic [7:0] data8 = 8'd0;
   logic       lv8 = 1'b0;
   logic       rdy8, sout8, sv8, busy8, done8;

   int checks = 0;
   int failures = 0;

   piso_tx #(.Width(4)) u4 (
      .CLK(CLK), .RST(RST), .Data(data4), .Load_valid(lv4), .Load_ready(rdy4),
      .Sout(sout4), .Sout_valid(sv4), .Busy(busy4), .Done(done4)
   );

   piso_tx #(.Width(8)) u8 (
      .CLK(CLK), .RST(RST), .Data(data8), .Load_valid(lv8), .Load_ready(rdy8),
      .Sout(sout8), .Sout_valid(sv8), .Busy(busy8), .Done(done8)
   );

   always #5 CLK = ~CLK;

   // expected outputs packed as {Sout, Sout_valid, Busy, Done, Load_ready}
   typedef struct {
      logic       lv;
      logic [3:0] data;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic lv, input logic [3:0] d, input logic [4:0] e);
      vec_t v;
      v.lv = lv;
      v.data = d;
      v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [4:0] outs4();
      return {sout4, sv4, busy4, done4, rdy4};
   endfunction

   localparam logic [4:0] B1   = 5'b11100; // shifting, bit 1
   localparam logic [4:0] B0   = 5'b01100; // shifting, bit 0
   localparam logic [4:0] DN   = 5'b00011; // idle with Done
   localparam logic [4:0] IDL  = 5'b00001; // idle

   initial begin
      // Frame 1011: bits 1,1,0,1 (+ parity 1)
      add(1'b1, 4'b1011, B1);
      add(1'b0, 4'b0000, B1);
      add(1'b0, 4'b0000, B0);
      add(1'b0, 4'b0000, B1);
`ifdef PISO_TX_PARITY_EN
      add(1'b0, 4'b0000, B1);
`endif
      add(1'b0, 4'b0000, DN);
      add(1'b0, 4'b0000, IDL);
      // Frame 0011 with Load_valid/Data offered while busy (ignored); parity 0
      add(1'b1, 4'b0011, B1);
      add(1'b1, 4'b1111, B1);
      add(1'b1, 4'b1111, B0);
      add(1'b1, 4'b1111, B0);
`ifdef PISO_TX_PARITY_EN
      add(1'b1, 4'b1111, B0);
`endif
      add(1'b0, 4'b1111, DN);
      add(1'b0, 4'b0000, IDL);
      // Back-to-back: 0110 then 1001 accepted in the Done cycle
      add(1'b1, 4'b0110, B0);
      add(1'b1, 4'b1111, B1);
      add(1'b1, 4'b0000, B1);
      add(1'b1, 4'b1111, B0);
`ifdef PISO_TX_PARITY_EN
      add(1'b1, 4'b1111, B0);
`endif
      add(1'b1, 4'b1111, DN);
      add(1'b1, 4'b1001, B1);
      add(1'b1, 4'b0000, B0);
      add(1'b1, 4'b0000, B0);
      add(1'b0, 4'b0000, B1);
`ifdef PISO_TX_PARITY_EN
      add(1'b0, 4'b0000, B0);
`endif
      add(1'b0, 4'b0000, DN);
      add(1'b0, 4'b0000, IDL);

      // Reset state before any clock edge
      #3;
      chk("reset_outs4", 32'(outs4()), 32'(IDL));
      chk("reset_outs8", 32'({sout8, sv8, busy8, done8, rdy8}), 32'(IDL));
      step();
      step();
      RST = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         lv4 = tbl[i].lv;
         data4 = tbl[i].data;
         step();
         chk($sformatf("vec%0d", i), 32'(outs4()), 32'(tbl[i].exp));
      end

      // Mid-frame reset during bit 2 of 1011
      lv4 = 1'b1;
      data4 = 4'b1011;
      step();
      lv4 = 1'b0;
      step();
      step();
      chk("bit2_before_rst", 32'(outs4()), 32'(B0));
      #2;
      RST = 1'b0;
      #1;
      chk("async_rst_outs", 32'(outs4()), 32'(IDL));
      chk("async_rst_cnt", 32'(u4.cnt_q), 32'd0);
      step();
      chk("rst_no_done", 32'(outs4()), 32'(IDL));
      RST = 1'b1;
      lv4 = 1'b1;
      data4 = 4'b0101;
      step();
      chk("post_rst_bit0", 32'(outs4()), 32'(B1));
      lv4 = 1'b0;
      step();
      chk("post_rst_bit1", 32'(outs4()), 32'(B0));
      step();
      chk("post_rst_bit2", 32'(outs4()), 32'(B1));
      step();
      chk("post_rst_bit3", 32'(outs4()), 32'(B0));
`ifdef PISO_TX_PARITY_EN
      step();
      chk("post_rst_par", 32'(outs4()), 32'(B0));
`endif
      step();
      chk("post_rst_done", 32'(outs4()), 32'(DN));

      // Width=8, 8'h80: seven 0 bits then a 1, counter ends at 8
      lv8 = 1'b1;
      data8 = 8'h80;
      step();
      lv8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("w8_bit%0d", i), 32'({sout8, sv8, busy8, done8}),
             (i == 7) ? 32'b1110 : 32'b0110);
         if (i == 7) chk("w8_cnt_last", 32'(u8.cnt_q), 32'd7);
         step();
      end
`ifdef PISO_TX_PARITY_EN
      chk("w8_par", 32'({sout8, sv8}), 32'b11);
      step();
`endif
      chk("w8_done", 32'({sout8, sv8, busy8, done8, rdy8}), 32'(DN));
      chk("w8_cnt_end", 32'(u8.cnt_q), 32'd8);
      step();
      chk("w8_idle", 32'({sout8, sv8, busy8, done8, rdy8}), 32'(IDL));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
